// File: rtl/adder_eval_pkg.sv
// Shared types and width helpers for the approximate-adder error sweep.
//   state_e        : sweep controller states
//   sum_w/cnt_w    : widths of an AUT sum (W+1) and of the pair counters (2W+1)
//   acc_w_default  : default err_sum width, 3W+1, large enough for a full sweep
//   WAIT_W         : width of the per-pair settle counter (LAT is 0..15)
package adder_eval_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned WAIT_W = 4;

  function automatic int unsigned sum_w(input int unsigned w);
    return w + 1;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned w);
    return 2 * w + 1;
  endfunction

  // Worst total is 2^(2W) * (2^(W+1) - 1) < 2^(3W+1).
  function automatic int unsigned acc_w_default(input int unsigned w);
    return 3 * w + 1;
  endfunction

endpackage

// File: rtl/approx_adder_err_sweep_if.sv
// Bundle of control, AUT-facing and result signals of the error sweep.
//   master : evaluation side (drives start/abort, returns the AUT sum)
//   slave  : sweep controller (drives operands, status and error metrics)
interface approx_adder_err_sweep_if
  import adder_eval_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ACC_W = acc_w_default(WIDTH)
);

  logic                 start;
  logic                 abort;
  logic                 busy;
  logic                 done;
  logic                 err_valid;
  logic [WIDTH-1:0]     dut_a;
  logic [WIDTH-1:0]     dut_b;
  logic [WIDTH:0]       dut_sum;
  logic [ACC_W-1:0]     err_sum;
  logic [WIDTH:0]       err_max;
  logic [2*WIDTH:0]     err_cnt;
  logic [WIDTH-1:0]     wce_a;
  logic [WIDTH-1:0]     wce_b;

  modport master (
    output start, abort, dut_sum,
    input  busy, done, err_valid, dut_a, dut_b,
           err_sum, err_max, err_cnt, wce_a, wce_b
  );

  modport slave (
    input  start, abort, dut_sum,
    output busy, done, err_valid, dut_a, dut_b,
           err_sum, err_max, err_cnt, wce_a, wce_b
  );

endinterface

// File: rtl/err_accum.sv
// Error datapath: absolute difference between exact and AUT sum, then
// sum / nonzero-count / strict-max accumulation with worst-case operands.
//   clk, rst     : clock, asynchronous active-high reset
//   clr_i        : zero all accumulators (has priority over en_i)
//   en_i         : accumulate the current pair this cycle
//   a_i, b_i     : operands currently applied to the AUT
//   sum_i        : AUT result for a_i + b_i
//   err_sum_o, err_max_o, err_cnt_o, wce_a_o, wce_b_o : registered metrics
module err_accum
  import adder_eval_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ACC_W = acc_w_default(WIDTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr_i,
  input  logic                         en_i,
  input  logic [WIDTH-1:0]             a_i,
  input  logic [WIDTH-1:0]             b_i,
  input  logic [WIDTH:0]               sum_i,
  output logic [ACC_W-1:0]             err_sum_o,
  output logic [WIDTH:0]               err_max_o,
  output logic [2*WIDTH:0]             err_cnt_o,
  output logic [WIDTH-1:0]             wce_a_o,
  output logic [WIDTH-1:0]             wce_b_o
);

  localparam int unsigned SUM_W = sum_w(WIDTH);
  localparam int unsigned CNT_W = cnt_w(WIDTH);

  logic [SUM_W-1:0] exact;
  logic [SUM_W-1:0] err;
  logic             err_nz;

  logic [ACC_W-1:0] sum_q, sum_d;
  logic [SUM_W-1:0] max_q, max_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] wa_q, wa_d;
  logic [WIDTH-1:0] wb_q, wb_d;

  always_comb begin
    exact  = SUM_W'(a_i) + SUM_W'(b_i);
    err    = (exact >= sum_i) ? (exact - sum_i) : (sum_i - exact);
    err_nz = (err != '0);

    sum_d = sum_q;
    max_d = max_q;
    cnt_d = cnt_q;
    wa_d  = wa_q;
    wb_d  = wb_q;

    if (clr_i) begin
      sum_d = '0;
      max_d = '0;
      cnt_d = '0;
      wa_d  = '0;
      wb_d  = '0;
    end else if (en_i) begin
      sum_d = sum_q + ACC_W'(err);
      cnt_d = cnt_q + CNT_W'(err_nz);
      // Strict compare: on a tie the earliest pair stays recorded.
      if (err > max_q) begin
        max_d = err;
        wa_d  = a_i;
        wb_d  = b_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
      max_q <= '0;
      cnt_q <= '0;
      wa_q  <= '0;
      wb_q  <= '0;
    end else begin
      sum_q <= sum_d;
      max_q <= max_d;
      cnt_q <= cnt_d;
      wa_q  <= wa_d;
      wb_q  <= wb_d;
    end
  end

  assign err_sum_o = sum_q;
  assign err_max_o = max_q;
  assign err_cnt_o = cnt_q;
  assign wce_a_o   = wa_q;
  assign wce_b_o   = wb_q;

endmodule

// File: rtl/approx_adder_err_sweep.sv
// Exhaustive error-characterisation controller for one approximate adder.
// Walks every (a, b) operand pair (b fastest), holds each pair for LAT+1
// cycles, samples the AUT sum on the last of them and accumulates error
// metrics through err_accum.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of approx_adder_err_sweep_if
//              start/abort in, busy/done/err_valid out,
//              dut_a/dut_b out to the AUT, dut_sum in from the AUT,
//              err_sum/err_max/err_cnt/wce_a/wce_b result outputs
module approx_adder_err_sweep
  import adder_eval_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LAT   = 0,
  parameter int unsigned ACC_W = acc_w_default(WIDTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  approx_adder_err_sweep_if.slave  bus
);

  localparam logic [WAIT_W-1:0] LAT_CNT = WAIT_W'(LAT);

  state_e            state_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WAIT_W-1:0] wait_q;
  logic              busy_q;
  logic              done_q;
  logic              valid_q;

  logic              sample_now;
  logic              acc_en;
  logic              acc_clr;
  logic              last_pair;

  always_comb begin
    sample_now = (state_q == ST_RUN) && (wait_q == LAT_CNT);
    // An abort in the sample cycle suppresses that pair's update.
    acc_en     = sample_now && !bus.abort;
    acc_clr    = (state_q == ST_IDLE) && bus.start;
    last_pair  = (&a_q) && (&b_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      wait_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            wait_q  <= '0;
          end
        end

        ST_RUN: begin
          if (bus.abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (wait_q == LAT_CNT) begin
            wait_q <= '0;
            if (last_pair) begin
              // Operands stay at all-ones after the final pair.
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              b_q <= b_q + 1'b1;
              if (&b_q) begin
                a_q <= a_q + 1'b1;
              end
            end
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          valid_q <= 1'b1;
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  err_accum #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W)
  ) u_err_accum (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (acc_clr),
    .en_i      (acc_en),
    .a_i       (a_q),
    .b_i       (b_q),
    .sum_i     (bus.dut_sum),
    .err_sum_o (bus.err_sum),
    .err_max_o (bus.err_max),
    .err_cnt_o (bus.err_cnt),
    .wce_a_o   (bus.wce_a),
    .wce_b_o   (bus.wce_b)
  );

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err_valid = valid_q;
  assign bus.dut_a     = a_q;
  assign bus.dut_b     = b_q;

endmodule

// File: tb/tb_approx_adder_err_sweep.sv
// Bench for approx_adder_err_sweep: three instances (W=2/LAT=0, W=2/LAT=2,
// W=8/LAT=0) each driven by a behavioural AUT stub selected by a mode:
//   0 exact, 1 constant zero, 2 exact^1, 3 wrong (7) for two cycles after
//   an operand change then exact.
module tb_approx_adder_err_sweep;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst_v;
  logic        start_v [3];
  logic        abort_v [3];
  int unsigned mode    [3];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct packed {
    logic [63:0] sum;
    logic [63:0] mx;
    logic [63:0] cnt;
    logic [63:0] wa;
    logic [63:0] wb;
  } res_t;

  res_t sb [$];

  approx_adder_err_sweep_if #(.WIDTH(2)) if0 ();
  approx_adder_err_sweep_if #(.WIDTH(2)) if1 ();
  approx_adder_err_sweep_if #(.WIDTH(8)) if2 ();

  approx_adder_err_sweep #(.WIDTH(2), .LAT(0)) u_dut0 (.clk(clk), .rst(rst_v[0]), .bus(if0));
  approx_adder_err_sweep #(.WIDTH(2), .LAT(2)) u_dut1 (.clk(clk), .rst(rst_v[1]), .bus(if1));
  approx_adder_err_sweep #(.WIDTH(8), .LAT(0)) u_dut2 (.clk(clk), .rst(rst_v[2]), .bus(if2));

  function automatic int unsigned stub_val(input int unsigned m, input int unsigned a,
                                           input int unsigned b, input int unsigned age);
    case (m)
      0:       return a + b;
      1:       return 0;
      2:       return (a + b) ^ 1;
      default: return (age < 2) ? 7 : a + b;
    endcase
  endfunction

  // Age of the current operand pair on instance 1, for the slow stub.
  logic [3:0]  prev1 = '0;
  int unsigned age1_q = 3;
  int unsigned age1;
  always_comb age1 = ({if1.dut_a, if1.dut_b} != prev1) ? 0 : age1_q;
  always_ff @(posedge clk) begin
    prev1  <= {if1.dut_a, if1.dut_b};
    age1_q <= (age1 >= 3) ? 3 : age1 + 1;
    cyc    <= cyc + 1;
  end

  always_comb begin
    if0.start   = start_v[0];
    if0.abort   = abort_v[0];
    if0.dut_sum = 3'(stub_val(mode[0], 32'(if0.dut_a), 32'(if0.dut_b), 3));
    if1.start   = start_v[1];
    if1.abort   = abort_v[1];
    if1.dut_sum = 3'(stub_val(mode[1], 32'(if1.dut_a), 32'(if1.dut_b), age1));
    if2.start   = start_v[2];
    if2.abort   = abort_v[2];
    if2.dut_sum = 9'(stub_val(mode[2], 32'(if2.dut_a), 32'(if2.dut_b), 3));
  end

  logic [2:0][63:0] o_sum, o_max, o_cnt, o_wa, o_wb, o_da, o_db;
  logic [2:0]       o_busy, o_done, o_valid;
  always_comb begin
    o_sum[0] = 64'(if0.err_sum); o_max[0] = 64'(if0.err_max); o_cnt[0] = 64'(if0.err_cnt);
    o_wa[0]  = 64'(if0.wce_a);   o_wb[0]  = 64'(if0.wce_b);
    o_da[0]  = 64'(if0.dut_a);   o_db[0]  = 64'(if0.dut_b);
    o_busy[0] = if0.busy; o_done[0] = if0.done; o_valid[0] = if0.err_valid;
    o_sum[1] = 64'(if1.err_sum); o_max[1] = 64'(if1.err_max); o_cnt[1] = 64'(if1.err_cnt);
    o_wa[1]  = 64'(if1.wce_a);   o_wb[1]  = 64'(if1.wce_b);
    o_da[1]  = 64'(if1.dut_a);   o_db[1]  = 64'(if1.dut_b);
    o_busy[1] = if1.busy; o_done[1] = if1.done; o_valid[1] = if1.err_valid;
    o_sum[2] = 64'(if2.err_sum); o_max[2] = 64'(if2.err_max); o_cnt[2] = 64'(if2.err_cnt);
    o_wa[2]  = 64'(if2.wce_a);   o_wb[2]  = 64'(if2.wce_b);
    o_da[2]  = 64'(if2.dut_a);   o_db[2]  = 64'(if2.dut_b);
    o_busy[2] = if2.busy; o_done[2] = if2.done; o_valid[2] = if2.err_valid;
  end

  function automatic int unsigned wsel(input int s);
    return (s == 2) ? 8 : 2;
  endfunction

  function automatic int unsigned lsel(input int s);
    return (s == 1) ? 2 : 0;
  endfunction

  // Expected metrics over the first npairs pairs in sweep order; the slow
  // stub (mode 3) is modelled at its settled value.
  function automatic res_t model(input int unsigned w, input int unsigned m,
                                 input int unsigned npairs);
    res_t r;
    int unsigned a, b, ex, s, e;
    r = '0;
    for (int unsigned k = 0; k < npairs; k++) begin
      a  = k >> w;
      b  = k & ((1 << w) - 1);
      ex = a + b;
      case (m)
        1:       s = 0;
        2:       s = ex ^ 1;
        default: s = ex;
      endcase
      e = (ex >= s) ? ex - s : s - ex;
      r.sum = r.sum + 64'(e);
      if (e != 0) r.cnt = r.cnt + 1;
      if (64'(e) > r.mx) begin
        r.mx = 64'(e);
        r.wa = 64'(a);
        r.wb = 64'(b);
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_results(input int sel, input string pfx, input res_t e);
    chk({pfx, "_err_sum"}, o_sum[sel], e.sum);
    chk({pfx, "_err_max"}, o_max[sel], e.mx);
    chk({pfx, "_err_cnt"}, o_cnt[sel], e.cnt);
    chk({pfx, "_wce_a"},   o_wa[sel],  e.wa);
    chk({pfx, "_wce_b"},   o_wb[sel],  e.wb);
  endtask

  task automatic chk_zero(input int sel, input string pfx);
    chk({pfx, "_busy"},  64'(o_busy[sel]),  0);
    chk({pfx, "_done"},  64'(o_done[sel]),  0);
    chk({pfx, "_valid"}, 64'(o_valid[sel]), 0);
    chk({pfx, "_dut_a"}, o_da[sel], 0);
    chk({pfx, "_dut_b"}, o_db[sel], 0);
    chk_results(sel, pfx, '0);
  endtask

  // Full sweep; poke_start pulses start mid-run, which must be ignored.
  task automatic sweep(input int sel, input int unsigned m, input bit poke_start);
    int unsigned w, n, s, nb;
    bit          got;
    res_t        e;
    w = wsel(sel);
    n = (1 << (2 * w)) * (lsel(sel) + 1);
    mode[sel] = m;
    @(negedge clk);
    start_v[sel] = 1'b1;
    sb.push_back(model(w, m, 1 << (2 * w)));
    s   = cyc;
    nb  = 0;
    got = 1'b0;
    @(negedge clk);
    start_v[sel] = 1'b0;
    chk("start_clears_valid", 64'(o_valid[sel]), 0);
    chk("start_clears_cnt",   o_cnt[sel], 0);
    chk("start_clears_max",   o_max[sel], 0);
    for (int unsigned i = 0; i < n + 8; i++) begin
      if (o_done[sel]) begin
        got = 1'b1;
        break;
      end
      if (o_busy[sel]) nb++;
      if (poke_start) start_v[sel] = (nb == 3);
      @(negedge clk);
    end
    start_v[sel] = 1'b0;
    chk("done_seen",     64'(got), 1);
    chk("done_cycle",    64'(cyc), 64'(s + 1 + n));
    chk("busy_cycles",   64'(nb),  64'(n));
    chk("valid_in_done", 64'(o_valid[sel]), 0);
    @(negedge clk);
    chk("done_one_cycle", 64'(o_done[sel]),  0);
    chk("busy_after",     64'(o_busy[sel]),  0);
    chk("valid_after",    64'(o_valid[sel]), 1);
    chk("final_dut_a",    o_da[sel], 64'((1 << w) - 1));
    chk("final_dut_b",    o_db[sel], 64'((1 << w) - 1));
    e = sb.pop_front();
    chk_results(sel, "sweep", e);
  endtask

  // Abort once nsamp pairs have been sampled; the abort cycle's pair is not.
  task automatic abort_run(input int sel, input int unsigned m, input int unsigned nsamp);
    int unsigned w;
    bit          saw_done;
    res_t        e;
    w = wsel(sel);
    mode[sel] = m;
    @(negedge clk);
    start_v[sel] = 1'b1;
    sb.push_back(model(w, m, nsamp));
    @(negedge clk);
    start_v[sel] = 1'b0;
    saw_done = 1'b0;
    repeat (nsamp) @(negedge clk);
    chk("busy_before_abort", 64'(o_busy[sel]), 1);
    abort_v[sel] = 1'b1;
    @(negedge clk);
    abort_v[sel] = 1'b0;
    chk("abort_busy",  64'(o_busy[sel]),  0);
    chk("abort_valid", 64'(o_valid[sel]), 0);
    e = sb.pop_front();
    chk_results(sel, "abort", e);
    for (int i = 0; i < 4; i++) begin
      if (o_done[sel]) saw_done = 1'b1;
      @(negedge clk);
    end
    chk("abort_no_done",  64'(saw_done), 0);
    chk("abort_stays_idle", 64'(o_busy[sel]), 0);
  endtask

  initial begin
    rst_v = '1;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      abort_v[i] = 1'b0;
      mode[i]    = 0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) chk_zero(i, "reset");
    rst_v = '0;

    sweep(0, 0, 1'b0);   // exact adder
    sweep(0, 1, 1'b0);   // constant zero
    sweep(0, 2, 1'b0);   // off by one everywhere, first-tie rule
    sweep(1, 3, 1'b0);   // slow AUT settles within LAT

    repeat (3) @(negedge clk);
    chk("hold_valid", 64'(o_valid[0]), 1);
    chk("hold_sum",   o_sum[0], model(2, 2, 16).sum);
    chk("hold_cnt",   o_cnt[0], model(2, 2, 16).cnt);

    abort_run(2, 1, 10);
    sweep(2, 1, 1'b0);

    // Asynchronous reset in the middle of a sweep.
    mode[0] = 1;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_busy",   64'(o_busy[0]), 1);
    chk("pre_rst_cnt_nz", 64'(o_cnt[0] != 0), 1);
    #2 rst_v[0] = 1'b1;
    #1 chk_zero(0, "async_rst");
    @(negedge clk);
    rst_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("no_autostart", 64'(o_busy[0]), 0);
    sweep(0, 0, 1'b1);   // start pulsed while busy

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
